map_cam_ctrl: RTL
=================

# map_cam_ctrl

Owns the architectural-to-physical tag array and its valid bits, and shares a single CAM search port between `NUM_REQ` requesters. Arbitration is round-robin. Each accepted search returns a registered response one cycle later, with backpressure. Sits beside the map table/retirement logic. Dispatch and retire requesters use it to turn a physical tag into its architectural index. Write, invalidate and flush ports keep the array coherent.

## Interface
- `ARRAY_SIZE`, default `ARCH_REGFILE_SIZE`: number of entries.
- `DATA_SIZE`, default `$clog2(PHYS_REGFILE_SIZE)`: tag width.
- `NUM_REQ`, default 2: number of search requesters.
- `clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: clear all valid bits and drop any pending response.
- `wr_en`, in, 1: write `wr_data` to entry `wr_idx` and set its valid bit.
- `wr_idx`, in, `$clog2(ARRAY_SIZE)`: entry index for the write.
- `wr_data`, in, `DATA_SIZE`: tag to write.
- `inv_en`, in, 1: clear the valid bit of entry `inv_idx`.
- `inv_idx`, in, `$clog2(ARRAY_SIZE)`: entry index for the invalidate.
- `req_valid`, in, `NUM_REQ`: per-requester search request.
- `req_data`, in, `NUM_REQ x DATA_SIZE`: per-requester search tag.
- `req_ready`, out, `NUM_REQ`: one-hot grant; the request is accepted when `req_valid[i] & req_ready[i]`.
- `resp_valid`, out, 1: response held in the output register.
- `resp_id`, out, `$clog2(NUM_REQ)` (min 1): requester that owns the response.
- `resp_hit`, out, 1: search matched a valid entry.
- `resp_idx`, out, `$clog2(ARRAY_SIZE)`: lowest matching index; 0 on a miss.
- `resp_ready`, in, 1: consumer takes the response.

## Operation
- **State:**
  - `array[ARRAY_SIZE]`
  - `valid[ARRAY_SIZE]`
  - round-robin pointer `rr_ptr`
  - output register (`resp_*`).
- **Reset values (while `reset` is low):** all of the above are 0, `req_ready` is 0, and all `resp_*` outputs are 0.
- **Output stage is free** when `!resp_valid || resp_ready`. `req_ready` may be nonzero only when the output stage is free and `flush` is 0.
- **Arbitration:**
  - Grant goes to the first `req_valid[i]`, scanning `i = rr_ptr, rr_ptr+1, ...` with modulo-`NUM_REQ` wrap.
  - At most one grant per cycle. Zero grants when no request is valid.
  - On acceptance, `rr_ptr` becomes `(granted+1) mod NUM_REQ`. Otherwise it holds.
- **Search:**
  - Runs combinationally in the accept cycle against `array`/`valid` as registered at the start of that cycle. A same-cycle write or invalidate is not seen.
  - Match rule: `array[k]==req_data[g] && valid[k]`. On multiple matches, the lowest `k` wins.
  - The result loads into the output register at the clock edge.
- **Output register:**
  - Loads on accept.
  - Clears `resp_valid` when it is free and nothing is accepted.
  - Holds all `resp_*` stable while `resp_valid && !resp_ready`.
- **Array update:**
  - If `wr_en` and `inv_en` target the same index in the same cycle, the write wins and valid becomes 1.
  - Writes and invalidates to different indices both apply.
- **Flush:**
  - Synchronous; takes priority over everything.
  - Next cycle: `valid` = 0 and `resp_valid` = 0.
  - `array` contents and `rr_ptr` are kept.
  - No request is accepted in the flush cycle.
  - `wr_en` in the flush cycle is ignored.

## Timing
- Search latency: accept at edge N; response visible after edge N (cycle N+1).
- Throughput: one search per cycle while `resp_ready` stays 1.
- A write or invalidate at edge N is visible to searches accepted at edge N+1 or later.
- A response is consumed at the edge where `resp_valid && resp_ready`. A new response can load at that same edge.
- `req_ready` depends combinationally on `resp_valid`, `resp_ready`, `flush`, `req_valid` and `rr_ptr`. It does not depend on `req_data`.
- Asserting reset mid-stall drops the pending response immediately (asynchronous). No partial state survives.

## Structure
- **Shared package** holds:
  - `ARCH_IDX_W = $clog2(ARCH_REGFILE_SIZE)` and `PHYS_TAG_W = $clog2(PHYS_REGFILE_SIZE)`
  - a `cam_resp_t` struct: `{valid, id, hit, idx}`.
- **Sub-modules:**
  - Instantiate the existing `CAM` combinational search with `enable` = accept. Do not re-implement the search.
  - Add one new sub-module, `rr_arbiter` (parameter `NUM_REQ`; inputs `req`, `en`, `ptr`; output one-hot `gnt`). It is reusable by issue logic.

## Test plan
- **Reset and single hit.** Reset low for 2 cycles, then all outputs are 0. Write entry 5 = tag 17. Next cycle, requester 0 searches 17. One cycle later: `resp_valid`=1, `resp_id`=0, `resp_hit`=1, `resp_idx`=5.
- **Miss, duplicate match, invalidate.**
  - Searching tag 40 on an empty array gives `resp_hit`=0, `resp_idx`=0.
  - Write entries 3 and 9 = tag 7, then search 7: `resp_idx`=3.
  - Invalidate 3, then search 7: `resp_idx`=9.
- **Round-robin fairness.** Both requesters are valid every cycle with `resp_ready`=1. Grants alternate 0,1,0,1. Responses stream back-to-back with matching `resp_id`.
- **Backpressure.** Hold `resp_ready`=0 for 3 cycles with an outstanding response. `resp_*` stays stable and `req_ready`=0. On release, the next grant goes to the requester after the last grant.
- **Same-cycle hazards.**
  - A search for tag 12 in the same cycle as writing entry 4 = 12 misses. A repeat search next cycle hits at `resp_idx`=4.
  - `wr_en`+`inv_en` on the same index leaves the entry valid.
- **Flush and async reset.**
  - Flush while a response is stalled: `resp_valid`=0 next cycle, and searching a previously valid tag misses.
  - Pull reset low mid-stream: outputs go to 0 before the next clock edge.

Source files
------------

// File: rtl/map_cam_ctrl_pkg.sv
// Shared widths and the response record for the map CAM controller.
package map_cam_ctrl_pkg;

    localparam int unsigned ARCH_REGFILE_SIZE = 32;
    localparam int unsigned PHYS_REGFILE_SIZE = 64;
    localparam int unsigned DEFAULT_NUM_REQ   = 2;

    localparam int unsigned ARCH_IDX_W = $clog2(ARCH_REGFILE_SIZE);
    localparam int unsigned PHYS_TAG_W = $clog2(PHYS_REGFILE_SIZE);
    localparam int unsigned REQ_ID_W   = (DEFAULT_NUM_REQ > 1) ? $clog2(DEFAULT_NUM_REQ) : 1;

    // Field widths bound the controller: ARRAY_SIZE <= ARCH_REGFILE_SIZE and
    // NUM_REQ <= DEFAULT_NUM_REQ rounded up to a power of two.
    typedef struct packed {
        logic                  valid;
        logic [REQ_ID_W-1:0]   id;
        logic                  hit;
        logic [ARCH_IDX_W-1:0] idx;
    } cam_resp_t;

endpackage

// File: rtl/CAM.sv
// Combinational tag search: lowest valid matching index wins.
module CAM #(
    parameter int unsigned ARRAY_SIZE = 32,
    parameter int unsigned DATA_SIZE  = 6,
    localparam int unsigned IDX_W     = $clog2(ARRAY_SIZE)
) (
    input  logic                                 enable,
    input  logic [DATA_SIZE-1:0]                 read_data,
    input  logic [ARRAY_SIZE-1:0][DATA_SIZE-1:0] array,
    input  logic [ARRAY_SIZE-1:0]                valid,
    output logic                                 hit,
    output logic [IDX_W-1:0]                     read_idx
);

    // Scan upward and latch the first match so the lowest index wins.
    always_comb begin
        hit      = 1'b0;
        read_idx = '0;
        for (int unsigned k = 0; k < ARRAY_SIZE; k++) begin
            if (enable && !hit && valid[k] && (array[k] == read_data)) begin
                hit      = 1'b1;
                read_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, with wrap, gets a one-hot grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    // Walk requesters starting at ptr; grant the first one that is asking.
    always_comb begin
        logic        found;
        int unsigned k;
        gnt   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            k = (32'(ptr) + j) % NUM_REQ;
            if (en && !found && req[k[PTR_W-1:0]]) begin
                gnt[k[PTR_W-1:0]] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/map_cam_ctrl.sv
// Tag array with valid bits and a round-robin shared CAM search port.
module map_cam_ctrl
    import map_cam_ctrl_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = ARCH_REGFILE_SIZE,
    parameter int unsigned DATA_SIZE  = $clog2(PHYS_REGFILE_SIZE),
    parameter int unsigned NUM_REQ    = 2,
    localparam int unsigned IDX_W     = $clog2(ARRAY_SIZE),
    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [DATA_SIZE-1:0]              wr_data,
    input  logic                              inv_en,
    input  logic [IDX_W-1:0]                  inv_idx,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              resp_valid,
    output logic [ID_W-1:0]                   resp_id,
    output logic                              resp_hit,
    output logic [IDX_W-1:0]                  resp_idx,
    input  logic                              resp_ready
);

    logic [ARRAY_SIZE-1:0][DATA_SIZE-1:0] array_q, array_d;
    logic [ARRAY_SIZE-1:0]                valid_q, valid_d;
    logic [ID_W-1:0]                      rr_ptr_q, rr_ptr_d;
    cam_resp_t                            resp_q, resp_d;

    logic                 out_free;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   gnt;
    logic                 accept;
    logic [ID_W-1:0]      gnt_idx;
    logic [DATA_SIZE-1:0] sel_data;
    logic                 cam_hit;
    logic [IDX_W-1:0]     cam_idx;

    // Grants are only offered when the output register can take a result;
    // reset gates them so req_ready reads 0 while reset is held low.
    always_comb begin
        out_free = !resp_q.valid || resp_ready;
        arb_en   = out_free && !flush && reset;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .en  (arb_en),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // Encode the one-hot grant and select the winning search tag.
    always_comb begin
        gnt_idx = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (gnt[j]) begin
                gnt_idx = ID_W'(j);
            end
        end
        accept    = |gnt;
        req_ready = gnt;
        sel_data  = req_data[gnt_idx];
    end

    CAM #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .DATA_SIZE  (DATA_SIZE)
    ) u_cam (
        .enable    (accept),
        .read_data (sel_data),
        .array     (array_q),
        .valid     (valid_q),
        .hit       (cam_hit),
        .read_idx  (cam_idx)
    );

    // Next state: array/valid updates, round-robin pointer and output register.
    always_comb begin
        array_d  = array_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        resp_d   = resp_q;

        if (flush) begin
            valid_d = '0;
            resp_d  = '0;
        end else begin
            // Invalidate first so a same-index write overrides it.
            if (inv_en) begin
                valid_d[inv_idx] = 1'b0;
            end
            if (wr_en) begin
                array_d[wr_idx] = wr_data;
                valid_d[wr_idx] = 1'b1;
            end

            if (accept) begin
                rr_ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                resp_d.valid = 1'b1;
                resp_d.id    = REQ_ID_W'(gnt_idx);
                resp_d.hit   = cam_hit;
                resp_d.idx   = ARCH_IDX_W'(cam_idx);
            end else if (out_free) begin
                resp_d.valid = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            array_q  <= '0;
            valid_q  <= '0;
            rr_ptr_q <= '0;
            resp_q   <= '0;
        end else begin
            array_q  <= array_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            resp_q   <= resp_d;
        end
    end

    // Response outputs come straight from the output register.
    always_comb begin
        resp_valid = resp_q.valid;
        resp_id    = resp_q.id[ID_W-1:0];
        resp_hit   = resp_q.hit;
        resp_idx   = resp_q.idx[IDX_W-1:0];
    end

endmodule
